width_packer: RTL and testbench
===============================

Name: width_packer

Overview:
- Upstream feeder stage for the parameterised-width display consumers: collects narrow W-bit beats and packs them into OUT_W-bit words (default 32).
- Valid/ready handshakes on both sides.
- Supports partial words via in_last, with a lane-keep mask.
- Instantiated once per tested width (8, 16, 32) alongside the consumer.

Parameters:
- W, 8, input beat width in bits; OUT_W % W must be 0, and W >= 1.
- OUT_W, 32, packed output word width in bits.
- LANES, OUT_W/W, beats per full word; derived, not to be overridden.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  single clock; all flops on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- in_data  input  W  beat payload.
- in_last  input  1  beat closes the current word early.
- out_valid  output  1  packed word available.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.
- out_data  output  OUT_W  packed word; lane 0 occupies bits [W-1:0].
- out_keep  output  LANES  bit i set means lane i holds real data.
- words_sent  output  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_keep=0, words_sent=0.
  - Lane counter=0, state=FILL.
  - in_ready=0 while rst is high.
- States:
  - FILL: accumulating beats; out_valid=0; in_ready=1.
  - HOLD: word presented; out_valid=1; in_ready=out_ready.
- Lane fill: an accepted beat in FILL writes in_data into lane[cnt] of the shadow word and sets keep[cnt]. Lanes are filled in ascending order, starting at lane 0 (little-endian).
- Word completion: the word completes on the accepted beat where cnt==LANES-1 or in_last=1.
  - Next cycle: out_data = shadow word, with unfilled lanes zero; out_keep = filled lanes; state=HOLD; cnt=0; shadow cleared.
  - Latency: from the completing beat to out_valid is 1 cycle.
- HOLD with out_ready=1:
  - Word is consumed; words_sent increments.
  - A beat accepted in the same cycle goes into lane 0 of the next word.
  - If that beat also completes a word (in_last=1, or LANES==1), the state stays HOLD with the new word. Otherwise the state goes to FILL.
  - Sustained throughput: one word per LANES cycles.
- HOLD with out_ready=0: out_data and out_keep are held stable; no beat is accepted.
- LANES==1 (W==OUT_W):
  - Every beat completes a word; out_keep is always 1.
  - The counter is degenerate, with a minimum width of 1 bit.
- in_last on an empty word (cnt==0): emits a word with keep=...0001. A zero-lane word is never emitted.
- in_valid=0: no state change. in_data is ignored unless the beat is accepted.
- words_sent: wraps from 2^CNT_W-1 to 0 without flagging.
- Reset mid-word: partial contents are discarded, and no word is emitted after release.
- Elaboration check: if OUT_W % W != 0, elaboration fails via an elaboration-time $error.

Decomposition:
- Shared package width_pkg holds:
  - function lanes_of(out_w, w);
  - function cnt_bits(n), equal to max(1, $clog2(n));
  - state enum {FILL, HOLD}.
- Optional sub-module packer_lane: one per lane, generated. Each instance holds a W-bit register and a keep flag, with write-enable and clear inputs.
- The top holds the FSM, the lane counter and words_sent.

Test Plan:
- W=8, out_ready=1, beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> one cycle later out_data=0x44332211, out_keep=4'b1111, words_sent=1.
- W=8, beats 0xAA then 0xBB with in_last=1 -> out_data=0x0000BBAA, out_keep=4'b0011. Then a lone beat 0x5C with in_last=1 -> out_data=0x0000005C, out_keep=4'b0001.
- W=16, out_ready=0 for 5 cycles after a word 0xBEEF_CAFE forms -> in_ready=0 and out_data stable for all 5 cycles. Then out_ready=1 with beat 0x1234 in the same cycle -> the next word has lane 0 = 0x1234.
- W=32, out_ready=1, 3 beats -> 3 words out, each with out_keep=1, each exactly 1 cycle after its beat; words_sent=3.
- W=8, rst asserted after 2 of 4 beats -> out_valid=0 and words_sent=0. After release, beats 0x01–0x04 -> 0x04030201, with no stale lanes.
- CNT_W=2, 5 completed words -> words_sent sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/width_pkg.sv
// Shared types and elaboration helpers for the width packer.
package width_pkg;

  // Packer control states.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Beats per packed output word.
  function automatic int lanes_of(input int out_w, input int w);
    return out_w / w;
  endfunction

  // Lane counter width; never narrower than one bit, even for a single lane.
  function automatic int cnt_bits(input int n);
    int b;
    b = $clog2(n);
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/packer_lane.sv
// One lane of the shadow word: a W-bit data register plus its keep flag.
module packer_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         keep
);

  // Clear wins over write: the completing beat is forwarded straight to the
  // output word, so the shadow copy is never needed after completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      keep <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      keep <= 1'b0;
    end else if (we) begin
      q    <= d;
      keep <= 1'b1;
    end
  end

endmodule

// File: rtl/width_packer.sv
// Packs W-bit beats into OUT_W-bit words, little-endian lane order, with
// early close via in_last and a per-lane keep mask.
//
// state | meaning
// ------+--------------------------------------------------------------
// FILL  | accumulating beats into the shadow word; out_valid low
// HOLD  | packed word presented; a beat is only taken when out_ready
module width_packer
  import width_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int OUT_W = 32,
  localparam int LANES = lanes_of(OUT_W, W),
  parameter  int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [LANES-1:0] out_keep,
  output logic [CNT_W-1:0] words_sent
);

  localparam int                CNT_LW    = cnt_bits(LANES);
  localparam logic [CNT_LW-1:0] LAST_LANE = CNT_LW'(LANES - 1);

  if (W < 1) begin : g_bad_w
    $error("width_packer: W must be at least 1");
  end else if ((OUT_W % W) != 0) begin : g_bad_ratio
    $error("width_packer: OUT_W must be a multiple of W");
  end

  state_e            state;
  logic [CNT_LW-1:0] cnt;
  logic [W-1:0]      lane_q [LANES];
  logic [LANES-1:0]  lane_keep;
  logic [OUT_W-1:0]  word_next;
  logic [LANES-1:0]  keep_next;
  logic              accept;
  logic              complete;

  // In HOLD a beat may only enter while the held word is leaving.
  assign in_ready = ~rst & ((state == FILL) | out_ready);
  assign accept   = in_valid & in_ready;
  assign complete = accept & (in_last | (cnt == LAST_LANE));

  // The lane being written is taken from in_data directly, so a completing
  // beat lands in the output word without first passing through the shadow.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic sel;
    assign sel = (cnt == CNT_LW'(i));

    packer_lane #(.W(W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .we   (accept & sel),
      .clr  (complete),
      .d    (in_data),
      .q    (lane_q[i]),
      .keep (lane_keep[i])
    );

    assign word_next[i*W +: W] = sel ? in_data : lane_q[i];
    assign keep_next[i]        = sel | lane_keep[i];
  end

  // Control FSM with lane counter, registered output word and handshake count.
  // The counter is always zero in HOLD, so a beat accepted there starts lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      words_sent <= '0;
    end else begin
      if (complete) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + CNT_LW'(1);
      end

      if (out_valid && out_ready) begin
        words_sent <= words_sent + CNT_W'(1);
      end

      if (complete) begin
        state     <= HOLD;
        out_valid <= 1'b1;
        out_data  <= word_next;
        out_keep  <= keep_next;
      end else if ((state == HOLD) && out_ready) begin
        state     <= FILL;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_width_packer.sv
// Scoreboard bench for width_packer at W=8, 16, 32 and a 2-bit word counter.
module tb_width_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } exp_t;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] out_ready;
  wire  [3:0] in_ready;
  wire  [3:0] ov;

  logic [7:0]  d0;
  logic [15:0] d1;
  logic [31:0] d2;
  logic [7:0]  d3;

  wire [31:0] od0, od1, od2, od3;
  wire [3:0]  kp0, kp3;
  wire [1:0]  kp1;
  wire [0:0]  kp2;
  wire [15:0] ws0, ws1, ws2;
  wire [1:0]  ws3;

  logic [31:0] od [4];
  logic [3:0]  kp [4];
  logic [15:0] ws [4];

  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = od2;
  assign od[3] = od3;
  assign kp[0] = kp0;
  assign kp[1] = {2'b00, kp1};
  assign kp[2] = {3'b000, kp2};
  assign kp[3] = kp3;
  assign ws[0] = ws0;
  assign ws[1] = ws1;
  assign ws[2] = ws2;
  assign ws[3] = {14'd0, ws3};

  exp_t sb [4][$];
  int   checks = 0;
  int   errors = 0;

  width_packer #(.W(8), .OUT_W(32), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(d0), .in_last(in_last[0]), .out_valid(ov[0]), .out_ready(out_ready[0]),
    .out_data(od0), .out_keep(kp0), .words_sent(ws0));

  width_packer #(.W(16), .OUT_W(32), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(d1), .in_last(in_last[1]), .out_valid(ov[1]), .out_ready(out_ready[1]),
    .out_data(od1), .out_keep(kp1), .words_sent(ws1));

  width_packer #(.W(32), .OUT_W(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(d2), .in_last(in_last[2]), .out_valid(ov[2]), .out_ready(out_ready[2]),
    .out_data(od2), .out_keep(kp2), .words_sent(ws2));

  width_packer #(.W(8), .OUT_W(32), .CNT_W(2)) dut8c (
    .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(d3), .in_last(in_last[3]), .out_valid(ov[3]), .out_ready(out_ready[3]),
    .out_data(od3), .out_keep(kp3), .words_sent(ws3));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for a single cycle; caller ensures the DUT can take it.
  task automatic beat(input int k, input logic [31:0] d, input logic last);
    in_valid[k] = 1'b1;
    in_last[k]  = last;
    case (k)
      0:       d0 = d[7:0];
      1:       d1 = d[15:0];
      2:       d2 = d;
      default: d3 = d[7:0];
    endcase
    #1;
    chk($sformatf("in_ready_dut%0d", k), {31'd0, in_ready[k]}, 32'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic [3:0] keep);
    exp_t e;
    e.data = d;
    e.keep = keep;
    sb[k].push_back(e);
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst[k] && ov[k] && out_ready[k]) begin
        checks++;
        if (sb[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_word dut%0d got data=%h keep=%b", k, od[k], kp[k]);
        end else begin
          exp_t e;
          e = sb[k].pop_front();
          if (od[k] !== e.data || kp[k] !== e.keep) begin
            errors++;
            $display("FAIL word_dut%0d got data=%h keep=%b expected data=%h keep=%b",
                     k, od[k], kp[k], e.data, e.keep);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int exp_ws [5];
    logic [31:0] w32 [3];

    clk       = 1'b0;
    rst       = 4'hF;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    // Reset state of every instance.
    idle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_out_valid_%0d", k), {31'd0, ov[k]}, 32'd0);
      chk($sformatf("rst_out_data_%0d", k), od[k], 32'd0);
      chk($sformatf("rst_out_keep_%0d", k), {28'd0, kp[k]}, 32'd0);
      chk($sformatf("rst_words_sent_%0d", k), {16'd0, ws[k]}, 32'd0);
      chk($sformatf("rst_in_ready_%0d", k), {31'd0, in_ready[k]}, 32'd0);
    end
    rst = 4'h0;
    idle();

    // Full 8-bit word, 1-cycle latency.
    out_ready[0] = 1'b1;
    beat(0, 32'h11, 1'b0);
    beat(0, 32'h22, 1'b0);
    beat(0, 32'h33, 1'b0);
    push(0, 32'h44332211, 4'b1111);
    beat(0, 32'h44, 1'b0);
    chk("t1_latency_valid", {31'd0, ov[0]}, 32'd1);
    chk("t1_data", od[0], 32'h44332211);
    idle();
    chk("t1_words_sent", {16'd0, ws[0]}, 32'd1);
    chk("t1_valid_drop", {31'd0, ov[0]}, 32'd0);

    // Partial word, then a lone in_last beat taken while the first is leaving.
    beat(0, 32'hAA, 1'b0);
    push(0, 32'h0000BBAA, 4'b0011);
    beat(0, 32'hBB, 1'b1);
    chk("t2_keep", {28'd0, kp[0]}, 32'h3);
    push(0, 32'h0000005C, 4'b0001);
    beat(0, 32'h5C, 1'b1);
    chk("t2_lone_valid", {31'd0, ov[0]}, 32'd1);
    chk("t2_lone_data", od[0], 32'h0000005C);
    idle();
    chk("t2_words_sent", {16'd0, ws[0]}, 32'd3);

    // 16-bit backpressure: word held stable, no beat taken.
    out_ready[1] = 1'b0;
    beat(1, 32'hCAFE, 1'b0);
    push(1, 32'hBEEFCAFE, 4'b0011);
    beat(1, 32'hBEEF, 1'b0);
    in_valid[1] = 1'b1;
    d1 = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_in_ready_hold_%0d", i), {31'd0, in_ready[1]}, 32'd0);
      chk($sformatf("t3_data_hold_%0d", i), od[1], 32'hBEEFCAFE);
      idle();
    end
    out_ready[1] = 1'b1;
    #1;
    chk("t3_in_ready_release", {31'd0, in_ready[1]}, 32'd1);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    push(1, 32'h56781234, 4'b0011);
    beat(1, 32'h5678, 1'b0);
    idle();
    chk("t3_words_sent", {16'd0, ws[1]}, 32'd2);

    // 32-bit: every beat is a word.
    out_ready[2] = 1'b1;
    w32[0] = 32'hDEADBEEF;
    w32[1] = 32'h01234567;
    w32[2] = 32'h89ABCDEF;
    for (int i = 0; i < 3; i++) begin
      push(2, w32[i], 4'b0001);
      beat(2, w32[i], 1'b0);
      chk($sformatf("t4_valid_%0d", i), {31'd0, ov[2]}, 32'd1);
      chk($sformatf("t4_data_%0d", i), od[2], w32[i]);
      chk($sformatf("t4_keep_%0d", i), {28'd0, kp[2]}, 32'd1);
    end
    idle();
    chk("t4_words_sent", {16'd0, ws[2]}, 32'd3);

    // Reset mid-word discards the partial lanes.
    beat(0, 32'hE1, 1'b0);
    beat(0, 32'hE2, 1'b0);
    rst[0] = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, ov[0]}, 32'd0);
    chk("t5_rst_words_sent", {16'd0, ws[0]}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready[0]}, 32'd0);
    idle();
    idle();
    rst[0] = 1'b0;
    idle();
    idle();
    chk("t5_no_stale_word", {31'd0, ov[0]}, 32'd0);
    beat(0, 32'h01, 1'b0);
    beat(0, 32'h02, 1'b0);
    beat(0, 32'h03, 1'b0);
    push(0, 32'h04030201, 4'b1111);
    beat(0, 32'h04, 1'b0);
    chk("t5_data", od[0], 32'h04030201);
    idle();
    chk("t5_words_sent", {16'd0, ws[0]}, 32'd1);

    // 2-bit completed-word counter wraps.
    out_ready[3] = 1'b1;
    exp_ws = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      push(3, 32'h10 + 32'(i), 4'b0001);
      beat(3, 32'h10 + 32'(i), 1'b1);
      idle();
      chk($sformatf("t6_words_sent_%0d", i), {16'd0, ws[3]}, 32'(exp_ws[i]));
    end

    idle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_dut%0d", k), 32'(sb[k].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
